// File: rtl/lt_fallback_ctrl_if.sv
// Fallback proposal channel: a new link configuration offered to the CR restart logic.
// Purely combinational bundle; no storage.
// Producer holds vld and data stable until the consumer raises rdy.
interface lt_fallback_ctrl_if #(
    parameter int BW_W = 8
);
    logic            fb_vld;
    logic            fb_rdy;
    logic [BW_W-1:0] fb_bw;
    logic [1:0]      fb_lc;
    logic            fb_retry;

    modport master (
        output fb_vld,
        output fb_bw,
        output fb_lc,
        output fb_retry,
        input  fb_rdy
    );

    modport slave (
        input  fb_vld,
        input  fb_bw,
        input  fb_lc,
        input  fb_retry,
        output fb_rdy
    );
endinterface

// File: rtl/lt_fallback_ctrl.sv
// Link-training fallback: retry the same config, then step lane count / rate down a ladder.
// Error at edge k -> fb_vld at k+2 (retry), k+3 (one step), k+4 (two chained steps).
// Proposal held stable in OUT until fb_rdy; errors arriving while not IDLE are dropped (err_drop).
module lt_fallback_ctrl #(
    parameter int                        BW_W        = 8,
    parameter int                        NUM_RATES   = 4,
    parameter logic [NUM_RATES*BW_W-1:0] RATE_LADDER = 32'h060A141E,
    parameter int                        MAX_LANES   = 4,
    parameter int                        MAX_RETRY   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 config_param_vld,
    input  logic [BW_W-1:0]      lpm_link_bw,
    input  logic [1:0]           lpm_link_lc,
    input  logic                 eq_start,
    input  logic [BW_W-1:0]      cur_bw,
    input  logic [1:0]           cur_lc,
    input  logic                 mode,
    input  logic                 cr_err,
    input  logic [3:0]           cr_dn,
    input  logic                 eq_err,
    input  logic                 lt_done,
    lt_fallback_ctrl_if.master   fb,
    output logic                 fb_failed,
    output logic                 busy,
    output logic                 err_drop
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EVAL  = 3'd1,
        LC_DN = 3'd2,
        BW_DN = 3'd3,
        OUT   = 3'd4,
        FAIL  = 3'd5
    } state_t;

    localparam logic [2:0] RETRY_LIM = 3'(MAX_RETRY);

    state_t          state_q, state_d;
    logic [BW_W-1:0] max_bw_q, max_bw_d;
    logic [1:0]      max_lc_q, max_lc_d;
    logic [BW_W-1:0] trial_bw_q, trial_bw_d;
    logic [1:0]      trial_lc_q, trial_lc_d;
    logic [2:0]      retry_cnt_q, retry_cnt_d;
    logic            err_cr_q, err_cr_d;
    logic [3:0]      cr_dn_q, cr_dn_d;
    logic            mode_q, mode_d;
    logic            restart_q, restart_d;
    logic            fb_vld_q, fb_vld_d;
    logic [BW_W-1:0] fb_bw_q, fb_bw_d;
    logic [1:0]      fb_lc_q, fb_lc_d;
    logic            fb_retry_q, fb_retry_d;
    logic            fb_failed_q, fb_failed_d;
    logic            busy_q, busy_d;
    logic            err_drop_q, err_drop_d;

    logic            has_next;
    logic            at_lowest;
    logic [BW_W-1:0] next_bw;
    logic [3:0]      lane_mask;
    logic            cr_any_active;
    logic [1:0]      lower_lc;
    logic [1:0]      lpm_lc_clamped;
    logic            any_err;

    // Ladder position of the trial rate, lane mask of the trial lane code and the lane cap.
    always_comb begin
        has_next = 1'b0;
        next_bw  = '0;
        for (int i = 0; i < NUM_RATES - 1; i++) begin
            if (!has_next && RATE_LADDER[i*BW_W +: BW_W] == trial_bw_q) begin
                has_next = 1'b1;
                next_bw  = RATE_LADDER[(i+1)*BW_W +: BW_W];
            end
        end
        at_lowest = (RATE_LADDER[(NUM_RATES-1)*BW_W +: BW_W] == trial_bw_q);

        case (trial_lc_q)
            2'b00:   lane_mask = 4'b0001;
            2'b11:   lane_mask = 4'b1111;
            default: lane_mask = 4'b0011;
        endcase
        // Only lanes inside the active width count as having locked.
        cr_any_active = |(cr_dn_q & lane_mask);
        lower_lc      = trial_lc_q[1] ? 2'b01 : 2'b00;

        if (MAX_LANES >= 4) begin
            lpm_lc_clamped = lpm_link_lc;
        end else if (MAX_LANES == 2) begin
            lpm_lc_clamped = (lpm_link_lc == 2'b11) ? 2'b01 : lpm_link_lc;
        end else begin
            lpm_lc_clamped = 2'b00;
        end

        any_err = cr_err || eq_err;
    end

    // Next-state and next-output computation for the fallback FSM and captured registers.
    always_comb begin
        state_d     = state_q;
        max_bw_d    = max_bw_q;
        max_lc_d    = max_lc_q;
        trial_bw_d  = trial_bw_q;
        trial_lc_d  = trial_lc_q;
        retry_cnt_d = retry_cnt_q;
        err_cr_d    = err_cr_q;
        cr_dn_d     = cr_dn_q;
        mode_d      = mode_q;
        restart_d   = restart_q;
        fb_bw_d     = fb_bw_q;
        fb_lc_d     = fb_lc_q;
        fb_retry_d  = fb_retry_q;

        case (state_q)
            IDLE: begin
                if (any_err) begin
                    state_d   = EVAL;
                    err_cr_d  = cr_err;
                    cr_dn_d   = cr_dn;
                    mode_d    = mode;
                    restart_d = 1'b0;
                end
            end
            EVAL: begin
                if (retry_cnt_q < RETRY_LIM) begin
                    retry_cnt_d = retry_cnt_q + 3'd1;
                    fb_bw_d     = trial_bw_q;
                    fb_lc_d     = trial_lc_q;
                    fb_retry_d  = 1'b1;
                    state_d     = OUT;
                end else begin
                    retry_cnt_d = 3'd0;
                    if (mode_q) begin
                        state_d = BW_DN;
                    end else if (err_cr_q && !cr_any_active) begin
                        // No active lane locked: the rate itself is suspect.
                        state_d = BW_DN;
                    end else begin
                        state_d = LC_DN;
                    end
                end
            end
            LC_DN: begin
                if (trial_lc_q != 2'b00) begin
                    fb_lc_d    = lower_lc;
                    fb_bw_d    = (!mode_q || restart_q) ? max_bw_q : trial_bw_q;
                    fb_retry_d = 1'b0;
                    state_d    = OUT;
                end else begin
                    state_d = mode_q ? FAIL : BW_DN;
                end
            end
            BW_DN: begin
                if (has_next) begin
                    fb_bw_d    = next_bw;
                    fb_lc_d    = mode_q ? trial_lc_q : max_lc_q;
                    fb_retry_d = 1'b0;
                    state_d    = OUT;
                end else if (at_lowest && mode_q) begin
                    // Rate-first ran out of rates: drop a lane and restart from the top rate.
                    restart_d = 1'b1;
                    state_d   = LC_DN;
                end else begin
                    state_d = FAIL;
                end
            end
            OUT: begin
                if (fb_vld_q && fb.fb_rdy) begin
                    state_d = IDLE;
                end
            end
            FAIL: begin
                if (config_param_vld) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Register updates from outside the sequence override the FSM's own retry update.
        if (config_param_vld) begin
            max_bw_d    = lpm_link_bw;
            max_lc_d    = lpm_lc_clamped;
            retry_cnt_d = 3'd0;
        end
        if (eq_start) begin
            trial_bw_d = cur_bw;
            trial_lc_d = cur_lc;
        end
        if (lt_done) begin
            retry_cnt_d = 3'd0;
        end

        // fb_vld rises one cycle after entering OUT and drops right after the handshake.
        fb_vld_d    = (state_q == OUT) && !(fb_vld_q && fb.fb_rdy);
        fb_failed_d = (state_q == FAIL) && !config_param_vld;
        busy_d      = (state_d != IDLE) && (state_d != FAIL);
        err_drop_d  = any_err && (state_q != IDLE);
    end

    // Single state/output register bank with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            max_bw_q    <= '0;
            max_lc_q    <= 2'b00;
            trial_bw_q  <= '0;
            trial_lc_q  <= 2'b00;
            retry_cnt_q <= 3'd0;
            err_cr_q    <= 1'b0;
            cr_dn_q     <= 4'b0000;
            mode_q      <= 1'b0;
            restart_q   <= 1'b0;
            fb_vld_q    <= 1'b0;
            fb_bw_q     <= '0;
            fb_lc_q     <= 2'b00;
            fb_retry_q  <= 1'b0;
            fb_failed_q <= 1'b0;
            busy_q      <= 1'b0;
            err_drop_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            max_bw_q    <= max_bw_d;
            max_lc_q    <= max_lc_d;
            trial_bw_q  <= trial_bw_d;
            trial_lc_q  <= trial_lc_d;
            retry_cnt_q <= retry_cnt_d;
            err_cr_q    <= err_cr_d;
            cr_dn_q     <= cr_dn_d;
            mode_q      <= mode_d;
            restart_q   <= restart_d;
            fb_vld_q    <= fb_vld_d;
            fb_bw_q     <= fb_bw_d;
            fb_lc_q     <= fb_lc_d;
            fb_retry_q  <= fb_retry_d;
            fb_failed_q <= fb_failed_d;
            busy_q      <= busy_d;
            err_drop_q  <= err_drop_d;
        end
    end

    assign fb.fb_vld   = fb_vld_q;
    assign fb.fb_bw    = fb_bw_q;
    assign fb.fb_lc    = fb_lc_q;
    assign fb.fb_retry = fb_retry_q;
    assign fb_failed   = fb_failed_q;
    assign busy        = busy_q;
    assign err_drop    = err_drop_q;

endmodule

// File: tb/tb_lt_fallback_ctrl.sv
// Bench for lt_fallback_ctrl: vector table of error scenarios plus hand-written corner sequences.
// Expected proposals are queued when an error is driven and compared when the DUT answers.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
module tb_lt_fallback_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       config_param_vld, eq_start, mode, cr_err, eq_err, lt_done;
    logic [7:0] lpm_link_bw, cur_bw;
    logic [1:0] lpm_link_lc, cur_lc;
    logic [3:0] cr_dn;
    logic       fb_failed, busy, err_drop;
    logic       cfg2, eqs2, cr_err2;
    logic       fb_failed2, busy2, err_drop2;

    lt_fallback_ctrl_if #(.BW_W(8)) fbi ();
    lt_fallback_ctrl_if #(.BW_W(8)) fbi2 ();

    lt_fallback_ctrl dut (
        .clk(clk), .rst(rst),
        .config_param_vld(config_param_vld), .lpm_link_bw(lpm_link_bw), .lpm_link_lc(lpm_link_lc),
        .eq_start(eq_start), .cur_bw(cur_bw), .cur_lc(cur_lc), .mode(mode),
        .cr_err(cr_err), .cr_dn(cr_dn), .eq_err(eq_err), .lt_done(lt_done),
        .fb(fbi), .fb_failed(fb_failed), .busy(busy), .err_drop(err_drop)
    );

    // Narrow lane cap and no retries: used to observe the lane-cap clamp directly.
    lt_fallback_ctrl #(.MAX_LANES(2), .MAX_RETRY(0)) dut2 (
        .clk(clk), .rst(rst),
        .config_param_vld(cfg2), .lpm_link_bw(lpm_link_bw), .lpm_link_lc(lpm_link_lc),
        .eq_start(eqs2), .cur_bw(cur_bw), .cur_lc(cur_lc), .mode(mode),
        .cr_err(cr_err2), .cr_dn(cr_dn), .eq_err(1'b0), .lt_done(1'b0),
        .fb(fbi2), .fb_failed(fb_failed2), .busy(busy2), .err_drop(err_drop2)
    );

    always #5 clk = ~clk;

    localparam int NPRE = 2;

    typedef struct {
        logic [7:0] max_bw;
        logic [1:0] max_lc;
        logic [7:0] tr_bw;
        logic [1:0] tr_lc;
        logic       md;
        logic [1:0] err;     // bit0 cr_err, bit1 eq_err
        logic [3:0] dn;
        logic       fail;
        logic [7:0] ebw;
        logic [1:0] elc;
        int         lat;
    } vec_t;

    typedef struct {
        logic       fail;
        logic [7:0] bw;
        logic [1:0] lc;
        logic       retry;
        int         lat;
    } exp_t;

    vec_t vt[12];
    exp_t exp_q[$];
    int   nvec = 0;
    int   nmis = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nmis++;
            $display("FAIL %s: got %0h, want %0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fire(input logic [1:0] err, input logic [3:0] dn);
        cr_err = err[0];
        eq_err = err[1];
        cr_dn  = dn;
        tick();
        cr_err = 1'b0;
        eq_err = 1'b0;
    endtask

    task automatic wait_out(output int lat, output bit got);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 12) begin
            tick();
            lat++;
            if (fbi.fb_vld || fb_failed) got = 1'b1;
        end
    endtask

    task automatic load(input logic [7:0] mb, input logic [1:0] ml, input logic [7:0] tb,
                        input logic [1:0] tl, input logic md);
        lpm_link_bw = mb; lpm_link_lc = ml;
        cur_bw = tb; cur_lc = tl; mode = md;
        config_param_vld = 1'b1; eq_start = 1'b1;
        tick();
        config_param_vld = 1'b0; eq_start = 1'b0;
    endtask

    // Drive one error, then compare the DUT's answer against the queued expectation.
    task automatic do_err(input string tag, input logic [1:0] err, input logic [3:0] dn,
                          input exp_t e, input bit hs);
        exp_t x;
        int   lat;
        bit   got;
        exp_q.push_back(e);
        fire(err, dn);
        wait_out(lat, got);
        x = exp_q.pop_front();
        chk({tag, " answered"}, 32'(got), 32'd1);
        if (got) begin
            chk({tag, " latency"}, 32'(lat), 32'(x.lat));
            chk({tag, " failed"}, 32'(fb_failed), 32'(x.fail));
            if (!x.fail) begin
                chk({tag, " bw"}, 32'(fbi.fb_bw), 32'(x.bw));
                chk({tag, " lc"}, 32'(fbi.fb_lc), 32'(x.lc));
                chk({tag, " retry"}, 32'(fbi.fb_retry), 32'(x.retry));
                if (hs) tick();
            end
        end
    endtask

    task automatic run_vec(input int i, input bit clear);
        vec_t v;
        v = vt[i];
        load(v.max_bw, v.max_lc, v.tr_bw, v.tr_lc, v.md);
        for (int r = 0; r < NPRE; r++) begin
            do_err($sformatf("v%0d pre%0d", i, r), v.err, v.dn,
                   '{1'b0, v.tr_bw, v.tr_lc, 1'b1, 2}, 1'b1);
        end
        do_err($sformatf("v%0d", i), v.err, v.dn,
               '{v.fail, v.ebw, v.elc, 1'b0, v.lat}, 1'b1);
        if (v.fail && clear) begin
            config_param_vld = 1'b1;
            tick();
            config_param_vld = 1'b0;
        end
    endtask

    initial begin
        int lat;
        int drops;
        bit got;
        logic [7:0] hold_bw;
        logic [1:0] hold_lc;

        //        max_bw max_lc tr_bw tr_lc md err dn       fail ebw    elc  lat
        vt[0]  = '{8'h1E, 2'b11, 8'h1E, 2'b11, 1'b0, 2'd2, 4'b0000, 1'b0, 8'h1E, 2'b01, 3};
        vt[1]  = '{8'h1E, 2'b11, 8'h14, 2'b11, 1'b0, 2'd1, 4'b0000, 1'b0, 8'h0A, 2'b11, 3};
        vt[2]  = '{8'h1E, 2'b11, 8'h06, 2'b00, 1'b0, 2'd2, 4'b0000, 1'b1, 8'h00, 2'b00, 4};
        vt[3]  = '{8'h1E, 2'b11, 8'h06, 2'b11, 1'b1, 2'd2, 4'b0000, 1'b0, 8'h1E, 2'b01, 4};
        vt[4]  = '{8'h1E, 2'b11, 8'h14, 2'b01, 1'b0, 2'd1, 4'b0010, 1'b0, 8'h1E, 2'b00, 3};
        vt[5]  = '{8'h1E, 2'b11, 8'h14, 2'b01, 1'b0, 2'd1, 4'b1100, 1'b0, 8'h0A, 2'b11, 3};
        vt[6]  = '{8'h1E, 2'b11, 8'h14, 2'b11, 1'b1, 2'd2, 4'b0000, 1'b0, 8'h0A, 2'b11, 3};
        vt[7]  = '{8'h1E, 2'b11, 8'h06, 2'b00, 1'b1, 2'd1, 4'b0000, 1'b1, 8'h00, 2'b00, 4};
        vt[8]  = '{8'h1E, 2'b11, 8'h10, 2'b11, 1'b1, 2'd2, 4'b0000, 1'b1, 8'h00, 2'b00, 3};
        vt[9]  = '{8'h14, 2'b01, 8'h0A, 2'b01, 1'b0, 2'd2, 4'b0000, 1'b0, 8'h14, 2'b00, 3};
        vt[10] = '{8'h14, 2'b01, 8'h06, 2'b01, 1'b0, 2'd1, 4'b0000, 1'b1, 8'h00, 2'b00, 3};
        vt[11] = '{8'h1E, 2'b11, 8'h14, 2'b11, 1'b0, 2'd3, 4'b0000, 1'b0, 8'h0A, 2'b11, 3};

        rst = 1'b1;
        config_param_vld = 1'b0; eq_start = 1'b0; mode = 1'b0;
        cr_err = 1'b0; eq_err = 1'b0; lt_done = 1'b0; cr_dn = 4'b0000;
        lpm_link_bw = 8'h00; lpm_link_lc = 2'b00; cur_bw = 8'h00; cur_lc = 2'b00;
        cfg2 = 1'b0; eqs2 = 1'b0; cr_err2 = 1'b0;
        fbi.fb_rdy = 1'b1;
        fbi2.fb_rdy = 1'b1;
        repeat (3) tick();

        // Reset state
        chk("rst fb_vld", 32'(fbi.fb_vld), 32'd0);
        chk("rst fb_bw", 32'(fbi.fb_bw), 32'd0);
        chk("rst fb_lc", 32'(fbi.fb_lc), 32'd0);
        chk("rst fb_retry", 32'(fbi.fb_retry), 32'd0);
        chk("rst fb_failed", 32'(fb_failed), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst err_drop", 32'(err_drop), 32'd0);
        rst = 1'b0;
        tick();

        // Table-driven scenarios
        for (int i = 0; i < 12; i++) run_vec(i, 1'b1);

        // Sticky failure, dropped errors and clearing by a new config
        run_vec(2, 1'b0);
        fire(2'b10, 4'b0000);
        chk("fail err_drop pulse", 32'(err_drop), 32'd1);
        chk("fail sticky", 32'(fb_failed), 32'd1);
        chk("fail busy", 32'(busy), 32'd0);
        tick();
        chk("fail err_drop one cycle", 32'(err_drop), 32'd0);
        chk("fail still sticky", 32'(fb_failed), 32'd1);
        config_param_vld = 1'b1;
        tick();
        config_param_vld = 1'b0;
        chk("fail cleared", 32'(fb_failed), 32'd0);

        // Backpressure: proposal held with fb_rdy low, mid-hold error dropped once
        load(8'h1E, 2'b11, 8'h1E, 2'b11, 1'b0);
        fbi.fb_rdy = 1'b0;
        do_err("hold", 2'b10, 4'b0000, '{1'b0, 8'h1E, 2'b11, 1'b1, 2}, 1'b0);
        hold_bw = 8'h1E;
        hold_lc = 2'b11;
        drops = 0;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) cr_err = 1'b1;
            tick();
            cr_err = 1'b0;
            chk($sformatf("hold%0d vld", c), 32'(fbi.fb_vld), 32'd1);
            chk($sformatf("hold%0d bw", c), 32'(fbi.fb_bw), 32'(hold_bw));
            chk($sformatf("hold%0d lc", c), 32'(fbi.fb_lc), 32'(hold_lc));
            chk($sformatf("hold%0d retry", c), 32'(fbi.fb_retry), 32'd1);
            if (err_drop) drops++;
        end
        chk("hold err_drop count", 32'(drops), 32'd1);
        fbi.fb_rdy = 1'b1;
        tick();
        chk("hold release vld", 32'(fbi.fb_vld), 32'd0);
        do_err("after hold", 2'b10, 4'b0000, '{1'b0, 8'h1E, 2'b11, 1'b1, 2}, 1'b1);

        // lt_done clears the retry budget
        load(8'h1E, 2'b11, 8'h1E, 2'b11, 1'b0);
        do_err("ltd r0", 2'b10, 4'b0000, '{1'b0, 8'h1E, 2'b11, 1'b1, 2}, 1'b1);
        do_err("ltd r1", 2'b10, 4'b0000, '{1'b0, 8'h1E, 2'b11, 1'b1, 2}, 1'b1);
        lt_done = 1'b1;
        tick();
        lt_done = 1'b0;
        do_err("ltd r2", 2'b10, 4'b0000, '{1'b0, 8'h1E, 2'b11, 1'b1, 2}, 1'b1);

        // Reset while evaluating an error
        load(8'h1E, 2'b11, 8'h06, 2'b00, 1'b0);
        fire(2'b01, 4'b0000);
        chk("eval busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        chk("mid rst fb_vld", 32'(fbi.fb_vld), 32'd0);
        chk("mid rst fb_bw", 32'(fbi.fb_bw), 32'd0);
        chk("mid rst fb_lc", 32'(fbi.fb_lc), 32'd0);
        chk("mid rst fb_retry", 32'(fbi.fb_retry), 32'd0);
        chk("mid rst fb_failed", 32'(fb_failed), 32'd0);
        chk("mid rst busy", 32'(busy), 32'd0);
        chk("mid rst err_drop", 32'(err_drop), 32'd0);
        rst = 1'b0;
        tick();

        // Lane cap of 2 clamps a 4-lane policy to lane code 01
        lpm_link_bw = 8'h1E; lpm_link_lc = 2'b11;
        cur_bw = 8'h1E; cur_lc = 2'b11; mode = 1'b0; cr_dn = 4'b0000;
        cfg2 = 1'b1; eqs2 = 1'b1;
        tick();
        cfg2 = 1'b0; eqs2 = 1'b0;
        cr_err2 = 1'b1;
        tick();
        cr_err2 = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 12) begin
            tick();
            lat++;
            if (fbi2.fb_vld || fb_failed2) got = 1'b1;
        end
        chk("cap answered", 32'(got), 32'd1);
        chk("cap latency", 32'(lat), 32'd3);
        chk("cap bw", 32'(fbi2.fb_bw), 32'h14);
        chk("cap lc", 32'(fbi2.fb_lc), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule

// File: doc/lt_fallback_ctrl.md
# lt_fallback_ctrl

Parametrised link-training fallback controller for the DP source link-training path. It sits between the channel-equalization FSM and the clock-recovery restart logic. On a clock-recovery or equalization failure it first retries the same link configuration a bounded number of times. After that it steps lane count and/or link rate down a configurable rate ladder, and reports either a new configuration through a valid/ready handshake or a terminal failure. It generalises the fixed 4-rate, lane-first checker with a parametrised ladder, a lane cap, a retry budget, and a selectable fallback order.

## Interface
Parameters:
- BW_W, 8, width of link-rate codes.
- NUM_RATES, 4, ladder entries (2..8).
- RATE_LADDER, 32'h060A141E, packed ladder, highest rate first; entry i = RATE_LADDER[i*BW_W +: BW_W] (default 1E,14,0A,06).
- MAX_LANES, 4, lane cap (1, 2 or 4).
- MAX_RETRY, 2, same-config retries before any fallback step (0..7).

Ports (synchronous reset, active-high; clock `clk`):
- clk  in  1  training clock.
- rst  in  1  synchronous active-high reset.
- config_param_vld  in  1  capture lpm_link_bw/lpm_link_lc; clears retry count and fail.
- lpm_link_bw  in  BW_W  policy-maker max rate.
- lpm_link_lc  in  2  policy-maker max lane code (00=1, 01=2, 11=4 lanes).
- eq_start  in  1  capture cur_bw/cur_lc as the active trial configuration.
- cur_bw  in  BW_W  active trial rate.
- cur_lc  in  2  active trial lane code.
- mode  in  1  0 = DP order, 1 = rate-first; sampled at error acceptance.
- cr_err  in  1  clock-recovery failure pulse.
- cr_dn  in  4  per-lane CR done; lanes at or above the active lane count are ignored.
- eq_err  in  1  channel-equalization failure pulse.
- lt_done  in  1  training success pulse; clears retry count.
- fb_vld  out  1  new configuration valid; restart CR.
- fb_rdy  in  1  consumer accepts the configuration.
- fb_bw  out  BW_W  proposed rate.
- fb_lc  out  2  proposed lane code.
- fb_retry  out  1  proposal is a same-config retry.
- fb_failed  out  1  sticky terminal failure.
- busy  out  1  state is not IDLE and not FAIL.
- err_drop  out  1  one-cycle pulse when an error arrives while busy or failed.

## Operation
- Captured registers: max_bw/max_lc (on config_param_vld; max_lc clamped to MAX_LANES code), trial_bw/trial_lc (on eq_start), retry_cnt (3 bits).
- States: IDLE, EVAL, LC_DN, BW_DN, OUT, FAIL.
- IDLE: cr_err or eq_err go to EVAL, latching the error type, cr_dn and mode. cr_err wins if both are high.
- EVAL:
  - If retry_cnt < MAX_RETRY: retry_cnt++, fb = trial config, fb_retry=1, go to OUT.
  - Otherwise retry_cnt=0, then:
    - mode 0 with cr_err and all active cr_dn bits 0: go to BW_DN.
    - mode 0, any other error: go to LC_DN.
    - mode 1: go to BW_DN.
- LC_DN:
  - If trial_lc is not 00: fb_lc = next lower code (11 to 01, 01 to 00). fb_bw = max_bw in mode 0, trial_bw in mode 1. Go to OUT.
  - If trial_lc is 00: mode 0 goes to BW_DN, mode 1 goes to FAIL.
- BW_DN: idx = ladder index matching trial_bw.
  - If idx < NUM_RATES-1: fb_bw = ladder[idx+1]; fb_lc = max_lc in mode 0, trial_lc in mode 1. Go to OUT.
  - At the lowest entry: mode 0 goes to FAIL. Mode 1 goes to LC_DN with the rate restart taken from max_bw.
  - trial_bw not in the ladder: go to FAIL.
- OUT: hold fb_vld, fb_bw, fb_lc and fb_retry stable until fb_rdy; on fb_vld&&fb_rdy go to IDLE.
- FAIL: fb_failed=1; errors are dropped. config_param_vld goes to IDLE and clears fb_failed.
- No state loop exists: every path ends in OUT or FAIL within 3 decision states.

## Timing
- Reset: state IDLE; fb_vld, fb_retry, fb_failed, busy and err_drop are 0; fb_bw and fb_lc are 0; all captured registers are 0.
- All outputs are registered.
- With an error sampled at edge k, fb_vld rises at edge:
  - k+2 for a retry,
  - k+3 for a single step,
  - k+4 for a LC_DN to BW_DN chain (or BW_DN to LC_DN in mode 1).
- fb_failed follows the same latency rule.
- fb_vld&&fb_rdy in cycle n gives fb_vld=0 at n+1; a new error may be accepted in IDLE at n+1.
- An error in any state other than IDLE sets err_drop at the next edge and causes no state change.
- config_param_vld or eq_start during an active sequence updates the registers. Decisions already taken are unaffected; later decisions use the new values.
- rst mid-sequence returns to the reset state at the next edge, overriding all inputs.

## Test plan
- max 1E/11, trial 1E/11, MAX_RETRY=2, three eq_err pulses (each accepted):
  - the first two give fb=1E/11 with fb_retry=1;
  - the third gives fb=1E/01 with fb_retry=0.
- mode 0, retry exhausted, cr_err with cr_dn=0000, trial 14/11, max lc 11: fb=0A/11, latency 3.
- mode 0, retry exhausted, eq_err with trial 06/00: LC_DN then BW_DN, then fb_failed=1 at k+4; later errors pulse err_drop; config_param_vld clears fb_failed.
- mode 1, retry exhausted, trial 06/11, max bw 1E: fb=1E/01.
- With fb_rdy held low for 5 cycles: fb_vld and fb data stay stable; a cr_err during the hold pulses err_drop once.
- MAX_LANES=2 with lpm_link_lc=11: max_lc captured as 01. Also: rst asserted while in EVAL leaves all outputs 0 on the next cycle.
